// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM: opcodes, state
// encoding, mux-select codes and the per-state control vector.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_IMM_WB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_r;
    logic       mem_w;
    logic       reg_w;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure state -> control-vector table; no gating by stall/reset here, the
// top applies that so this stays a Moore lookup.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_r     = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        // branch target is precomputed here while the RF is read
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: o_ctrl.mem_r = 1'b1;
      S_MEM_WR: o_ctrl.mem_w = 1'b1;
      S_MEM_WB: begin
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_IMM_WB: begin
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle CPU datapath plus a retired-instruction
// counter. Stall freezes the FSM and masks every write enable.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             stall,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_r,
  output logic             mem_w,
  output logic             reg_w,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_we_ok;
  logic             w_legal;
  ctrl_t            w_ctrl;

  assign w_legal = is_legal(opcode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else if (!stall) begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_R:         w_next = S_EXEC_R;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            // unknown opcode retires as a NOP
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = S_MEM_WB;
      S_EXEC_R:  w_next = S_ALU_WB;
      S_EXEC_I:  w_next = S_IMM_WB;
      S_MEM_WB, S_MEM_WR, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  mc_out_decode u_dec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // reset masks every strobe; stall masks writes but keeps the read strobe
  assign w_we_ok       = rst_n & ~stall;
  assign pc_write      = w_ctrl.pc_write      & w_we_ok;
  assign pc_write_cond = w_ctrl.pc_write_cond & w_we_ok;
  assign ir_write      = w_ctrl.ir_write      & w_we_ok;
  assign mem_w         = w_ctrl.mem_w         & w_we_ok;
  assign reg_w         = w_ctrl.reg_w         & w_we_ok;
  assign mem_r         = w_ctrl.mem_r         & rst_n;
  assign reg_dst       = w_ctrl.reg_dst;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_src        = w_ctrl.pc_src;
  assign illegal       = (r_state == S_DECODE) & ~w_legal & w_we_ok;
  assign state_o       = r_state;
  assign retired       = r_retired;

endmodule
